// File: rtl/f_predictpc_if.sv
// Fetch-side predictor bus: fetch lookup, resolved-branch update
// and mispredict statistics. master = core side, slave = predictor.
interface f_predictpc_if;
  logic [12:0] fetch_pc;
  logic [12:0] pc_predicted;
  logic [1:0]  pred_slot;
  logic        upd_valid;
  logic [12:0] upd_pc;
  logic [1:0]  upd_jump_code;
  logic        upd_taken;
  logic [12:0] upd_target;
  logic        fail_predict;
  logic [15:0] mispredict_count;

  modport master (
    output fetch_pc,
    output upd_valid,
    output upd_pc,
    output upd_jump_code,
    output upd_taken,
    output upd_target,
    output fail_predict,
    input  pc_predicted,
    input  pred_slot,
    input  mispredict_count
  );

  modport slave (
    input  fetch_pc,
    input  upd_valid,
    input  upd_pc,
    input  upd_jump_code,
    input  upd_taken,
    input  upd_target,
    input  fail_predict,
    output pc_predicted,
    output pred_slot,
    output mispredict_count
  );
endinterface

// File: rtl/f_predictpc.sv
// Direct-mapped BTB with 2-bit counters predicting the next fetch-pair PC.
// Ports: clk, rst_n (async low), bus (f_predictpc_if.slave).
module f_predictpc #(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 7
) (
  input logic          clk,
  input logic          rst_n,
  f_predictpc_if.slave bus
);
  localparam int N = 1 << IDX_BITS;

  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [TAG_BITS-1:0] tag_t;

  logic [N-1:0] valid_q;
  tag_t         tag_q [N];
  logic [12:0]  tgt_q [N];
  logic [1:0]   ctr_q [N];
  logic [15:0]  cnt_q;

  logic [12:0] pc1;
  logic [12:0] pc2;
  logic [12:0] pc_ft;
  idx_t        idx1;
  idx_t        idx2;
  tag_t        tag1;
  tag_t        tag2;
  logic        hit1;
  logic        hit2;

  assign pc1   = bus.fetch_pc;
  assign pc2   = bus.fetch_pc + 13'd1;
  assign pc_ft = bus.fetch_pc + 13'd2;
  assign idx1  = pc1[IDX_BITS-1:0];
  assign idx2  = pc2[IDX_BITS-1:0];
  assign tag1  = pc1[12:IDX_BITS];
  assign tag2  = pc2[12:IDX_BITS];

  assign hit1 = valid_q[idx1]
              & (tag_q[idx1] == tag1)
              & ctr_q[idx1][1];
  assign hit2 = valid_q[idx2]
              & (tag_q[idx2] == tag2)
              & ctr_q[idx2][1];

  always_comb begin
    bus.pred_slot    = 2'b00;
    bus.pc_predicted = pc_ft;
    unique case (1'b1)
      hit1: begin
        bus.pred_slot    = 2'b01;
        bus.pc_predicted = tgt_q[idx1];
      end
      (hit2 & ~hit1): begin
        bus.pred_slot    = 2'b10;
        bus.pc_predicted = tgt_q[idx2];
      end
      default: ;
    endcase
  end

  idx_t u_idx;
  tag_t u_tag;
  logic u_en;
  logic u_jal;
  logic u_taken;
  logic u_match;

  assign u_idx   = bus.upd_pc[IDX_BITS-1:0];
  assign u_tag   = bus.upd_pc[12:IDX_BITS];
  assign u_en    = bus.upd_valid & (|bus.upd_jump_code);
  assign u_jal   = bus.upd_jump_code[1];
  assign u_taken = u_jal | bus.upd_taken;
  assign u_match = valid_q[u_idx] & (tag_q[u_idx] == u_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
    end else if (u_en) begin
      if (u_taken) begin
        tgt_q[u_idx] <= bus.upd_target;
        if (u_match) begin
          if (u_jal || ctr_q[u_idx] == 2'b11)
            ctr_q[u_idx] <= 2'b11;
          else
            ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
        end else begin
          valid_q[u_idx] <= 1'b1;
          tag_q[u_idx]   <= u_tag;
          ctr_q[u_idx]   <= u_jal ? 2'b11 : 2'b10;
        end
      end else if (u_match) begin
        if (ctr_q[u_idx] != 2'b00)
          ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (bus.upd_valid && bus.fail_predict
             && cnt_q != 16'hFFFF)
      cnt_q <= cnt_q + 16'd1;
  end

  assign bus.mispredict_count = cnt_q;
endmodule

// File: doc/f_predictpc.md
Name: f_predictpc

Overview:
- Fetch-side branch predictor for the dual-issue RV32I core. It supplies the predicted next fetch PC for the instruction pair {fetch_pc, fetch_pc+1}.
- The D-stage PC-resolution logic compares that prediction against its computed true PC. It then returns the resolved outcome here.
- Implemented as a direct-mapped BTB with 2-bit saturating counters and a mispredict statistics counter.
- PCs are 13-bit word addresses.

Parameters:
- IDX_BITS, 6, BTB index width; the BTB has 2^IDX_BITS entries. Index = pc[IDX_BITS-1:0].
- TAG_BITS, 7, tag width; must equal 13-IDX_BITS. Tag = pc[12:IDX_BITS].

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- fetch_pc  input  13  word PC of fetch slot 1; slot 2 is fetch_pc+1.
- pc_predicted  output  13  predicted PC of the next fetch pair.
- pred_slot  output  2  01 = slot 1 predicted taken, 10 = slot 2 predicted taken, 00 = fall-through.
- upd_valid  input  1  a resolved control-transfer instruction is presented this cycle.
- upd_pc  input  13  word PC of the resolved instruction.
- upd_jump_code  input  2  00 none, 01 conditional branch, 10 jal, 11 jalr.
- upd_taken  input  1  branch condition result; ignored for jal/jalr.
- upd_target  input  13  resolved target (the true PC when taken).
- fail_predict  input  1  D stage reports a mispredict for this update.
- mispredict_count  output  16  saturating count of reported mispredicts.

Behaviour:

Storage, per entry:
- valid (1 bit), tag (TAG_BITS), target (13), ctr (2).

Reset (rst_n low, asynchronous):
- All valid = 0, all ctr = 01, mispredict_count = 0.
- Outputs during and after reset: pred_slot = 00, pc_predicted = fetch_pc+2.

Lookup (combinational from registered table state, zero latency):
- hitN = valid[idxN] & tag[idxN] == tagN & ctr[idxN][1], where slot N uses fetch_pc (N=1) or fetch_pc+1 (N=2).
- Priority:
  - hit1 → pred_slot = 01, pc_predicted = target[idx1].
  - else hit2 → pred_slot = 10, pc_predicted = target[idx2].
  - else → pred_slot = 00, pc_predicted = fetch_pc+2.
- All PC arithmetic is 13-bit modulo 8192. fetch_pc+1 and fetch_pc+2 wrap; 13'h1FFF pairs with 13'h0000.
- Slot 1 and slot 2 always differ in index when IDX_BITS ≥ 1.

Update (rising edge, only when upd_valid = 1 and upd_jump_code != 00):
- taken = upd_jump_code[1] | upd_taken.
- match = valid & tag == upd tag at idx(upd_pc).
- taken & match:
  - target ← upd_target.
  - ctr ← 11 for jal/jalr; otherwise increment, saturating at 11.
- taken & !match:
  - Allocate or overwrite: valid ← 1, tag, target ← upd_target.
  - ctr ← 11 for jal/jalr, 10 for branch.
- !taken & match: ctr decrements, saturating at 00. Entry stays valid.
- !taken & !match: no change (no allocation on not-taken).
- upd_valid = 0 or upd_jump_code = 00: table unchanged.

Timing:
- Update written at edge T is visible to lookup from cycle T+1.
- No bypass: a same-cycle lookup of the index being written sees the old contents.
- One update per cycle maximum.

mispredict_count:
- Increments at the edge when upd_valid & fail_predict.
- Holds at 16'hFFFF.
- Independent of the table update rules; counted even when upd_jump_code = 00.

Reset mid-operation:
- Asynchronous clear of all state regardless of a pending update.
- The first edge after rst_n deasserts performs a normal update if presented.

Test Plan:
1. Reset then fetch_pc=0x010 with no updates → pred_slot=00, pc_predicted=0x012; mispredict_count=0.
2. Update upd_pc=0x010, jump_code=01, taken=1, target=0x040, fail_predict=1. Next cycle, fetch_pc=0x010 → pred_slot=01, pc_predicted=0x040 (ctr 10), mispredict_count=1.
3. With the entry from scenario 2 present:
   - Two not-taken updates at 0x010 → ctr 10→01→00; fetch_pc=0x010 predicts 0x012.
   - One taken update → ctr 01, still not predicted.
   - Second taken update → ctr 10, predicts 0x040.
4. jal update upd_pc=0x025, target=0x100. Then fetch_pc=0x024 → pred_slot=10, pc_predicted=0x100. Then fetch_pc=0x025 → pred_slot=01.
5. Alias test:
   - Entry at 0x010 predicted taken; fetch_pc=0x050 (same index, different tag) → fall-through 0x052.
   - Taken update at 0x050 (target=0x200) evicts it; fetch_pc=0x010 → 0x012.
   - Wrap case: fetch_pc=0x1FFF with no hits → pc_predicted=0x0001.
6. Same-cycle update and lookup of index 0x08 → old prediction that cycle, new prediction next cycle. Also: assert rst_n low mid-stream → table cleared immediately; 65537 mispredict updates → mispredict_count holds 16'hFFFF.
